// File: rtl/shift_arbiter_pkg.sv
// Opcode constants and decode helper shared by shift_arbiter and its shifter.
// SHIFT_ARBITER_ASR_EN enables arithmetic-right decode for OP_ASR; otherwise it passes through.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

package shift_arbiter_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LSL = 3'b000,
    OP_LSR = 3'b001,
    OP_ROL = 3'b010,
    OP_ROR = 3'b011,
    OP_ASR = 3'b100
  } op_e;

  typedef struct packed {
    logic rot;
    logic left;
`ifdef SHIFT_ARBITER_ASR_EN
    logic sign;
`endif
    logic pass;
  } shift_ctrl_t;

  // Unlisted opcodes (and OP_ASR when sign-fill is compiled out) pass a through.
  function automatic shift_ctrl_t decode_op(input logic [OP_W-1:0] op);
    shift_ctrl_t c;
    c = '0;
    case (op)
      OP_LSL: c.left = 1'b1;
      OP_LSR: c.left = 1'b0;
      OP_ROL: begin
        c.rot  = 1'b1;
        c.left = 1'b1;
      end
      OP_ROR: c.rot = 1'b1;
`ifdef SHIFT_ARBITER_ASR_EN
      OP_ASR: c.sign = 1'b1;
`endif
      default: c.pass = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational barrel shifter: logical/rotate left/right, optional sign fill (SHIFT_ARBITER_ASR_EN).
// Zero latency; no flow control.
module shift_arbiter_shifter #(
  parameter int N = `DEFAULT_WIDTH,
  localparam int SW = $clog2(N)
) (
`ifdef SHIFT_ARBITER_ASR_EN
  input  logic          sign_i,
`endif
  input  logic [N-1:0]  a_i,
  input  logic [SW-1:0] amt_i,
  input  logic          rot_i,
  input  logic          left_i,
  output logic [N-1:0]  y_o
);

  logic [SW:0]  inv_amt;
  logic [N-1:0] rol, ror, srl, sr;

  // Shifting by N yields zero, so amt = 0 rotates cleanly without a special case.
  assign inv_amt = (SW+1)'(N) - {1'b0, amt_i};
  assign rol     = (a_i << amt_i) | (a_i >> inv_amt);
  assign ror     = (a_i >> amt_i) | (a_i << inv_amt);
  assign srl     = a_i >> amt_i;

`ifdef SHIFT_ARBITER_ASR_EN
  assign sr = (sign_i && a_i[N-1]) ? (srl | ~({N{1'b1}} >> amt_i)) : srl;
`else
  assign sr = srl;
`endif

  always_comb begin
    y_o = sr;
    if (rot_i) begin
      y_o = left_i ? rol : ror;
    end else if (left_i) begin
      y_o = a_i << amt_i;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter feeding one shifter into a single result register; 1-cycle latency.
// Readies drop while the result slot is full and not being drained; SHIFT_ARBITER_ASR_EN enables ASR.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int N = `DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [N-1:0]         req0_a,
  input  logic [$clog2(N)-1:0] req0_b,
  input  logic [OP_W-1:0]      req0_op,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [N-1:0]         req1_a,
  input  logic [$clog2(N)-1:0] req1_b,
  input  logic [OP_W-1:0]      req1_op,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N-1:0]         res_data,
  output logic                 res_src
);

  localparam int SW = $clog2(N);

  logic         res_valid_q, res_valid_d;
  logic [N-1:0] res_data_q, res_data_d;
  logic         res_src_q, res_src_d;
  logic         ptr_q, ptr_d;

  logic          slot_free, gnt0, gnt1, xfer, sel;
  logic [N-1:0]  mux_a, shift_y;
  logic [SW-1:0] mux_b, amt;
  logic [OP_W-1:0] mux_op;
  shift_ctrl_t   ctrl;

  // Grants use only handshake state so readies never depend on operand data.
  assign slot_free  = !res_valid_q || res_ready;
  assign gnt0       = !rst && slot_free && req0_valid && (!req1_valid || !ptr_q);
  assign gnt1       = !rst && slot_free && req1_valid && (!req0_valid || ptr_q);
  assign xfer       = gnt0 || gnt1;
  assign sel        = gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign mux_a  = sel ? req1_a  : req0_a;
  assign mux_b  = sel ? req1_b  : req0_b;
  assign mux_op = sel ? req1_op : req0_op;
  assign ctrl   = decode_op(mux_op);
  assign amt    = ctrl.pass ? '0 : mux_b;

  shift_arbiter_shifter #(.N(N)) u_shifter (
`ifdef SHIFT_ARBITER_ASR_EN
    .sign_i (ctrl.sign),
`endif
    .a_i    (mux_a),
    .amt_i  (amt),
    .rot_i  (ctrl.rot),
    .left_i (ctrl.left),
    .y_o    (shift_y)
  );

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_src_d   = res_src_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      res_valid_d = 1'b1;
      res_data_d  = shift_y;
      res_src_d   = sel;
      ptr_d       = !sel;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_src_q   <= 1'b0;
      ptr_q       <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_src_q   <= res_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_src   = res_src_q;

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: N, default `DEFAULT_WIDTH, datapath width; power of two, N >= 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a  input  N  requester 0 operand.
REQ-007 req0_b  input  $clog2(N)  requester 0 shift amount.
REQ-008 req0_op  input  3  requester 0 opcode.
REQ-009 req1_valid / req1_ready / req1_a / req1_b / req1_op: same widths and meaning for requester 1.
REQ-010 res_valid  output  1  result register holds a result.
REQ-011 res_ready  input  1  consumer takes result this cycle.
REQ-012 res_data  output  N  shifted result.
REQ-013 res_src  output  1  index of requester that produced res_data.

Function
REQ-014 Opcodes: 000 LSL, 001 LSR, 010 ROL, 011 ROR, 100 ASR; fill bit 0 for LSL/LSR, a[N-1] for ASR.
REQ-015 Opcodes 101-111: accepted normally, res_data = operand a unmodified.
REQ-016 Transfer on a port occurs when valid and ready both high at a clock edge.
REQ-017 Slot free = !res_valid || res_ready (drain and refill in the same cycle allowed).
REQ-018 Grant: only one reqX_ready high per cycle; readies zero when slot not free.
REQ-019 One valid requester with slot free: that requester granted.
REQ-020 Both valid with slot free: requester named by round-robin pointer granted.
REQ-021 Pointer updates only on a transfer, to the non-granted requester; otherwise holds.
REQ-022 readyX depends combinationally on valid inputs, res_valid, res_ready, pointer only; never on a, b, op.
REQ-023 Latency: transfer at edge k -> res_valid, res_data, res_src valid after edge k (one cycle).
REQ-024 res_data/res_src held stable while res_valid && !res_ready.
REQ-025 Result drained, no new transfer -> res_valid low next cycle.
REQ-026 b = 0 -> res_data = a for every opcode.
REQ-027 Sustained throughput: one result per cycle when res_ready held high.

Reset
REQ-028 On rst: res_valid = 0, res_data = 0, res_src = 0, pointer = requester 0.
REQ-029 During rst cycle: req0_ready = req1_ready = 0; no transfer occurs.
REQ-030 rst asserted with result pending: result discarded, never presented.

Configuration
REQ-031 Macro SHIFT_ARBITER_ASR_EN defined: opcode 100 performs ASR per REQ-014.
REQ-032 Macro undefined: opcode 100 treated as REQ-015 pass-through; no sign-fill logic generated.

Structure
REQ-033 Shared package/defines: opcode constants (OP_LSL..OP_ASR) and opcode width 3.
REQ-034 Datapath: exactly one instance of existing shifter sub-module, input muxed from granted requester; rot/left/sign decoded from opcode.
REQ-035 Result register plus 1-bit pointer are sole state; no FSM beyond res_valid.

Verification (N = 8)
REQ-036 req0 a=8'b10000111 b=3 op=ROL, res_ready=1 -> next cycle res_data=8'b00111100, res_src=0.
REQ-037 Both valid every cycle, res_ready=1, after reset -> grants 0,1,0,1; res_src alternates.
REQ-038 Result pending, res_ready=0 for 3 cycles -> res_data stable, both readies low; on res_ready=1 new transfer same cycle.
REQ-039 a=8'b10000111 b=2 op=100 -> 8'b11100001 with SHIFT_ARBITER_ASR_EN, 8'b10000111 without.
REQ-040 rst asserted while res_valid=1 -> next cycle res_valid=0, res_data=0, pointer favours req0.
